// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared 7-segment definitions for the display scanner encoder and
//           the frame-capture receiver: gfedcba glyph codes, segment bit
//           indices and the timeout sizing helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

   // Glyph codes, bit order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG7_0     = 7'h3F;
   localparam logic [6:0] SEG7_1     = 7'h06;
   localparam logic [6:0] SEG7_2     = 7'h5B;
   localparam logic [6:0] SEG7_3     = 7'h4F;
   localparam logic [6:0] SEG7_4     = 7'h66;
   localparam logic [6:0] SEG7_5     = 7'h6D;
   localparam logic [6:0] SEG7_6     = 7'h7D;
   localparam logic [6:0] SEG7_7     = 7'h07;
   localparam logic [6:0] SEG7_8     = 7'h7F;
   localparam logic [6:0] SEG7_9     = 7'h6F;
   localparam logic [6:0] SEG7_A     = 7'h77;
   localparam logic [6:0] SEG7_B     = 7'h7C;
   localparam logic [6:0] SEG7_C     = 7'h39;
   localparam logic [6:0] SEG7_D     = 7'h5E;
   localparam logic [6:0] SEG7_E     = 7'h79;
   localparam logic [6:0] SEG7_F     = 7'h71;
   localparam logic [6:0] SEG7_BLANK = 7'h00;

   // Bit positions inside the 8-bit segment bus {dp,g,f,e,d,c,b,a}
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Number of clk cycles in the no-frame timeout window (never below 1)
   function automatic int seg7_timeout_cycles(input int clkfreq, input int timeout_ms);
      int n;
      n = (clkfreq / 1000) * timeout_ms;
      if (n < 1) begin
         n = 1;
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_glyph_decode
// Purpose : Combinational decode of a 7-bit gfedcba glyph back to a hex nibble.
// Ports   : glyph_i  [6:0] active-high segment pattern {g,f,e,d,c,b,a}
//           known_o        glyph is one of the 16 hex glyphs
//           blank_o        glyph is all segments off
//           nibble_o [3:0] decoded value (0 for blank or unknown)
// Revision: 1.0 - initial release
// ============================================================================
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] glyph_i,
   output logic       known_o,
   output logic       blank_o,
   output logic [3:0] nibble_o
);

   always_comb begin
      known_o  = 1'b1;
      blank_o  = 1'b0;
      nibble_o = 4'h0;
      case (glyph_i)
         SEG7_0:     nibble_o = 4'h0;
         SEG7_1:     nibble_o = 4'h1;
         SEG7_2:     nibble_o = 4'h2;
         SEG7_3:     nibble_o = 4'h3;
         SEG7_4:     nibble_o = 4'h4;
         SEG7_5:     nibble_o = 4'h5;
         SEG7_6:     nibble_o = 4'h6;
         SEG7_7:     nibble_o = 4'h7;
         SEG7_8:     nibble_o = 4'h8;
         SEG7_9:     nibble_o = 4'h9;
         SEG7_A:     nibble_o = 4'hA;
         SEG7_B:     nibble_o = 4'hB;
         SEG7_C:     nibble_o = 4'hC;
         SEG7_D:     nibble_o = 4'hD;
         SEG7_E:     nibble_o = 4'hE;
         SEG7_F:     nibble_o = 4'hF;
         SEG7_BLANK: begin
            known_o = 1'b0;
            blank_o = 1'b1;
         end
         default:    known_o = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seg7_frame_capture.sv
`default_nettype none
// ============================================================================
// Module  : seg7_frame_capture
// Purpose : Receiver for a 4-digit multiplexed 7-segment display bus. Samples
//           the strobes/segments, waits for a settled one-hot strobe, decodes
//           each glyph and publishes the reassembled 16-bit value.
// Ports   : clk, rst            clock, synchronous active-high reset
//           digits_i   [3:0]    digit strobes (async), bit i -> nibble i
//           segments_i [7:0]    {dp,g,f,e,d,c,b,a} (async)
//           dat_o      [15:0]   last complete frame, digit0 = dat_o[3:0]
//           dp_o       [3:0]    decimal points of last frame
//           valid_o             one-cycle pulse when dat_o/dp_o update
//           err_o               pulse with valid_o if any glyph was unknown
//           stale_o             no frame published within TIMEOUT_MS
// Revision: 1.0 - initial release
// ============================================================================
module seg7_frame_capture
   import seg7_pkg::*;
#(
   parameter int CLKFREQ          = 27_000_000,
   parameter int DIGIT_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW   = 1,
   parameter int SETTLE_CYCLES    = 4,
   parameter int TIMEOUT_MS       = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  digits_i,
   input  logic [7:0]  segments_i,
   output logic [15:0] dat_o,
   output logic [3:0]  dp_o,
   output logic        valid_o,
   output logic        err_o,
   output logic        stale_o
);

   // Pin levels meaning "nothing lit"; XOR with these normalises to active-high
   localparam logic [3:0] DIG_IDLE = (DIGIT_ACTIVE_LOW != 0) ? 4'hF  : 4'h0;
   localparam logic [7:0] SEG_IDLE = (SEG_ACTIVE_LOW   != 0) ? 8'hFF : 8'h00;

   localparam int TO_CYCLES = seg7_timeout_cycles(CLKFREQ, TIMEOUT_MS);
   localparam int STW       = $clog2(SETTLE_CYCLES + 1);
   localparam int TOW       = $clog2(TO_CYCLES + 1);

   localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);
   localparam logic [STW-1:0] SETTLE_MAX  = STW'(SETTLE_CYCLES);
   localparam logic [TOW-1:0] TO_LAST     = TOW'(TO_CYCLES - 1);
   localparam logic [TOW-1:0] TO_MAX      = TOW'(TO_CYCLES);

   // Synchronizer and stability tracking
   logic [3:0]     dig_s1_q, dig_s2_q;
   logic [7:0]     seg_s1_q, seg_s2_q;
   logic [11:0]    prev_q,   prev_d;
   logic [STW-1:0] stab_q,   stab_d;

   // Frame assembly
   logic [15:0]    nib_sh_q, nib_sh_d;
   logic [3:0]     dp_sh_q,  dp_sh_d;
   logic [3:0]     seen_q,   seen_d;
   logic [3:0]     bad_q,    bad_d;

   // Timeout
   logic [TOW-1:0] to_cnt_q, to_cnt_d;
   logic           stale_q,  stale_d;

   // Published outputs
   logic [15:0]    dat_q,    dat_d;
   logic [3:0]     dp_q,     dp_d;
   logic           valid_q,  valid_d;
   logic           err_q,    err_d;

   // Combinational helpers
   logic [3:0]     dig_n;
   logic [7:0]     seg_n;
   logic           onehot;
   logic           stable_ok;
   logic           capture;
   logic           publish;
   logic           expire;
   logic           dec_known;
   logic           dec_blank;
   logic [3:0]     dec_nib;

   seg7_glyph_decode u_decode (
      .glyph_i  (seg_n[SEG_G:SEG_A]),
      .known_o  (dec_known),
      .blank_o  (dec_blank),
      .nibble_o (dec_nib)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         dig_s1_q <= DIG_IDLE;
         dig_s2_q <= DIG_IDLE;
         seg_s1_q <= SEG_IDLE;
         seg_s2_q <= SEG_IDLE;
         prev_q   <= '0;
         stab_q   <= '0;
         nib_sh_q <= '0;
         dp_sh_q  <= '0;
         seen_q   <= '0;
         bad_q    <= '0;
         to_cnt_q <= '0;
         stale_q  <= 1'b0;
         dat_q    <= '0;
         dp_q     <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         dig_s1_q <= digits_i;
         dig_s2_q <= dig_s1_q;
         seg_s1_q <= segments_i;
         seg_s2_q <= seg_s1_q;
         prev_q   <= prev_d;
         stab_q   <= stab_d;
         nib_sh_q <= nib_sh_d;
         dp_sh_q  <= dp_sh_d;
         seen_q   <= seen_d;
         bad_q    <= bad_d;
         to_cnt_q <= to_cnt_d;
         stale_q  <= stale_d;
         dat_q    <= dat_d;
         dp_q     <= dp_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      dig_n     = dig_s2_q ^ DIG_IDLE;
      seg_n     = seg_s2_q ^ SEG_IDLE;
      onehot    = (dig_n != 4'h0) && ((dig_n & (dig_n - 4'h1)) == 4'h0);
      stable_ok = onehot && ({dig_n, seg_n} == prev_q);
      prev_d    = {dig_n, seg_n};

      // Saturating counter: the LAST->MAX step happens once per episode,
      // so it doubles as the single capture strobe
      stab_d  = '0;
      capture = 1'b0;
      if (stable_ok) begin
         stab_d  = (stab_q == SETTLE_MAX) ? stab_q : stab_q + STW'(1);
         capture = (stab_q == SETTLE_LAST);
      end

      publish = (seen_q == 4'hF);
      expire  = !publish && (to_cnt_q == TO_LAST);

      if (publish) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TO_MAX) begin
         to_cnt_d = to_cnt_q;
      end else begin
         to_cnt_d = to_cnt_q + TOW'(1);
      end

      if (publish) begin
         stale_d = 1'b0;
      end else if (expire) begin
         stale_d = 1'b1;
      end else begin
         stale_d = stale_q;
      end

      // Publishing or expiring empties the frame; a capture on that same
      // edge then lands as the first digit of the following frame
      seen_d   = (publish || expire) ? 4'h0 : seen_q;
      bad_d    = (publish || expire) ? 4'h0 : bad_q;
      nib_sh_d = nib_sh_q;
      dp_sh_d  = dp_sh_q;
      if (capture) begin
         seen_d = seen_d | dig_n;
         for (int i = 0; i < 4; i++) begin
            if (dig_n[i]) begin
               nib_sh_d[4*i +: 4] = dec_nib;
               dp_sh_d[i]         = seg_n[SEG_DP];
               bad_d[i]           = !(dec_known || dec_blank);
            end
         end
      end

      dat_d   = publish ? nib_sh_q : dat_q;
      dp_d    = publish ? dp_sh_q  : dp_q;
      valid_d = publish;
      err_d   = publish && (bad_q != 4'h0);
   end

   assign dat_o   = dat_q;
   assign dp_o    = dp_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;
   assign stale_o = stale_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_frame_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_seg7_frame_capture
// Purpose : Self-checking bench for seg7_frame_capture using directed and
//           randomized scans against a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_frame_capture;

   localparam int SETTLE = 4;
   localparam int CLKF   = 1_000_000;
   localparam int TOMS   = 1;
   localparam int HOLD   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  digits;
   logic [7:0]  segments;
   logic [15:0] dat_o;
   logic [3:0]  dp_o;
   logic        valid_o;
   logic        err_o;
   logic        stale_o;

   always #5 clk = ~clk;

   seg7_frame_capture #(
      .CLKFREQ          (CLKF),
      .DIGIT_ACTIVE_LOW (1),
      .SEG_ACTIVE_LOW   (1),
      .SETTLE_CYCLES    (SETTLE),
      .TIMEOUT_MS       (TOMS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_i   (digits),
      .segments_i (segments),
      .dat_o      (dat_o),
      .dp_o       (dp_o),
      .valid_o    (valid_o),
      .err_o      (err_o),
      .stale_o    (stale_o)
   );

   typedef struct packed {
      logic [15:0] dat;
      logic [3:0]  dp;
      logic        err;
      logic        stale;
   } ev_t;

   int checks = 0;
   int errors = 0;
   int stray_err = 0;

   logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model: one frame's worth of per-digit slots
   logic [3:0] m_nib  [4];
   logic       m_dp   [4];
   logic       m_bad  [4];
   logic [3:0] m_seen;

   ev_t exp_q[$];
   ev_t got_q[$];
   ev_t ev_m;

   always @(negedge clk) begin
      if (valid_o) begin
         ev_m.dat   = dat_o;
         ev_m.dp    = dp_o;
         ev_m.err   = err_o;
         ev_m.stale = stale_o;
         got_q.push_back(ev_m);
      end
      if (err_o && !valid_o) stray_err++;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int lookup(input logic [6:0] g);
      for (int i = 0; i < 16; i++) begin
         if (glyph_tab[i] == g) return i;
      end
      return -1;
   endfunction

   task automatic model_clear();
      m_seen = 4'h0;
      for (int i = 0; i < 4; i++) m_bad[i] = 1'b0;
   endtask

   task automatic model_capture(input int d, input logic [6:0] g, input logic dp);
      int  v;
      ev_t e;
      v = lookup(g);
      m_nib[d]  = (v < 0) ? 4'h0 : v[3:0];
      m_bad[d]  = (v < 0) && (g != 7'h00);
      m_dp[d]   = dp;
      m_seen[d] = 1'b1;
      if (m_seen == 4'hF) begin
         e.dat   = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
         e.dp    = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
         e.err   = m_bad[0] | m_bad[1] | m_bad[2] | m_bad[3];
         e.stale = 1'b0;
         exp_q.push_back(e);
         model_clear();
      end
   endtask

   // Drive active-high strobes/segments onto the active-low pins for n cycles
   task automatic drive(input logic [3:0] dig_act, input logic [7:0] seg_act, input int n);
      digits   = ~dig_act;
      segments = ~seg_act;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One digit of a scan followed by a short blanking gap
   task automatic show(input int d, input logic [6:0] g, input logic dp, input int n);
      logic [3:0] m;
      m = 4'b0001 << d;
      drive(m, {dp, g}, n);
      if (n >= SETTLE + 2) model_capture(d, g, dp);
      drive(4'h0, 8'h00, 2);
   endtask

   task automatic scan(input logic [15:0] v, input logic [3:0] dps);
      for (int d = 0; d < 4; d++) show(d, glyph_tab[v[4*d +: 4]], dps[d], HOLD);
   endtask

   task automatic compare_events(input string tag);
      ev_t e;
      ev_t g;
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "/count"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) begin
            g = got_q.pop_front();
            chk({tag, "/dat"},   g.dat,   e.dat);
            chk({tag, "/dp"},    g.dp,    e.dp);
            chk({tag, "/err"},   g.err,   e.err);
            chk({tag, "/stale"}, g.stale, e.stale);
         end
      end
      got_q.delete();
   endtask

   function automatic logic [6:0] rand_bad();
      logic [6:0] g;
      g = 7'($urandom_range(1, 127));
      while (lookup(g) >= 0) g = 7'($urandom_range(1, 127));
      return g;
   endfunction

   initial begin
      logic [6:0] g;
      int         order [4];
      int         tmp, j, extras;
      logic [15:0] a_val;

      model_clear();
      rst = 1'b1;
      drive(4'h0, 8'h00, 3);
      chk("reset/dat",   dat_o,   16'h0);
      chk("reset/dp",    dp_o,    4'h0);
      chk("reset/valid", valid_o, 1'b0);
      chk("reset/err",   err_o,   1'b0);
      chk("reset/stale", stale_o, 1'b0);
      rst = 1'b0;
      drive(4'h0, 8'h00, 2);

      // 1: plain scan of 1,2,3,4
      scan(16'h4321, 4'h0);
      compare_events("t1");
      chk("t1/dat_hold", dat_o, 16'h4321);
      chk("t1/dp_hold",  dp_o,  4'h0);

      // 2: unknown glyph on digit 2
      show(0, glyph_tab[1], 1'b0, HOLD);
      show(1, glyph_tab[2], 1'b0, HOLD);
      show(2, 7'h2A,        1'b0, HOLD);
      show(3, glyph_tab[4], 1'b0, HOLD);
      compare_events("t2");
      chk("t2/dat_hold", dat_o, 16'h4021);

      // Randomized frames: random pre-strobes (latest wins) then a shuffled full scan
      for (int f = 0; f < 8; f++) begin
         extras = $urandom_range(0, 3);
         for (int k = 0; k < extras; k++) begin
            show($urandom_range(0, 3), glyph_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1)), HOLD);
         end
         for (int i = 0; i < 4; i++) order[i] = i;
         for (int i = 3; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
         end
         for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 7))
               0:       g = rand_bad();
               1:       g = 7'h00;
               default: g = glyph_tab[$urandom_range(0, 15)];
            endcase
            show(order[i], g, 1'($urandom_range(0, 1)), HOLD);
         end
         compare_events("rand");
      end

      // 3: too-short holds never capture, so the frame times out
      for (int k = 0; k < 60; k++) begin
         for (int d = 0; d < 4; d++) show(d, glyph_tab[d + 5], 1'b0, SETTLE - 1);
      end
      compare_events("t3");
      chk("t3/stale", stale_o, 1'b1);
      model_clear();

      // 4: overlapping strobes mid-scan are ignored
      show(0, glyph_tab[7], 1'b1, HOLD);
      show(1, glyph_tab[8], 1'b0, HOLD);
      show(2, glyph_tab[9], 1'b0, HOLD);
      drive(4'b0110, {1'b0, glyph_tab[15]}, 20);
      drive(4'h0, 8'h00, 2);
      show(3, glyph_tab[10], 1'b1, HOLD);
      compare_events("t4");
      chk("t4/dat_hold", dat_o,   16'hA987);
      chk("t4/dp_hold",  dp_o,    4'b1001);
      chk("t4/stale",    stale_o, 1'b0);

      // 5: publish A, starve past the timeout, then publish B
      a_val = 16'($urandom);
      scan(a_val, 4'b0010);
      compare_events("t5a");
      drive(4'h0, 8'h00, 900);
      chk("t5/stale_early", stale_o, 1'b0);
      drive(4'h0, 8'h00, 200);
      chk("t5/stale_late", stale_o, 1'b1);
      chk("t5/dat_hold",   dat_o,   a_val);
      chk("t5/dp_hold",    dp_o,    4'b0010);
      scan(~a_val, 4'b0100);
      compare_events("t5b");
      chk("t5/stale_clear", stale_o, 1'b0);

      // 6: reset mid-frame discards the partial frame
      show(0, glyph_tab[3], 1'b1, HOLD);
      show(1, glyph_tab[3], 1'b1, HOLD);
      rst = 1'b1;
      drive(4'h0, 8'h00, 3);
      chk("t6/rst_dat",   dat_o,   16'h0);
      chk("t6/rst_dp",    dp_o,    4'h0);
      chk("t6/rst_valid", valid_o, 1'b0);
      chk("t6/rst_stale", stale_o, 1'b0);
      rst = 1'b0;
      model_clear();
      exp_q.delete();
      got_q.delete();
      drive(4'h0, 8'h00, 2);
      show(2, glyph_tab[12], 1'b0, HOLD);
      show(3, glyph_tab[13], 1'b0, HOLD);
      compare_events("t6_partial");
      show(0, glyph_tab[14], 1'b0, HOLD);
      show(1, glyph_tab[11], 1'b0, HOLD);
      compare_events("t6");
      chk("t6/dat_hold", dat_o, 16'hDCBE);

      chk("stray_err", stray_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
